// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants for the two-port memory arbiter
//
// Purpose: FSM state encodings, grant identifiers and latency counter width
//          used by mem_port_arbiter and its sub-modules.
// Ports:   none (package)
package mem_port_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    // Grant id doubles as the steering select: 1 picks requester A.
    localparam logic GRANT_A = 1'b1;
    localparam logic GRANT_B = 1'b0;

    // Latency counter width; supports MEM_LAT of 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// rtl/mem_port_arbiter_mux2.sv - generic 2:1 data mux
//
// Purpose: steering mux; sel=1 passes in_a, sel=0 passes in_b.
// Ports:   sel  - select
//          in_a - first input (chosen when sel=1)
//          in_b - second input (chosen when sel=0)
//          out  - selected data
module mux2 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] out
);

    assign out = sel ? in_a : in_b;

endmodule

// File: rtl/mem_port_arbiter_rr_grant_picker.sv
// rtl/mem_port_arbiter_rr_grant_picker.sv - two-way round-robin grant decision
//
// Purpose: combinational choice between requesters A and B; on a tie the
//          requester that did not win last time is chosen.
// Ports:   req_a       - request from A
//          req_b       - request from B
//          last_grant  - id of previous winner (1=A, 0=B)
//          grant_valid - at least one request present
//          grant_id    - winner id (1=A, 0=B)
module rr_grant_picker
    import mem_port_arbiter_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req_a | req_b;
        if (req_a && req_b) begin
            grant_id = ~last_grant;
        end else if (req_a) begin
            grant_id = GRANT_A;
        end else begin
            grant_id = GRANT_B;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for one fixed-latency memory port
//
// Purpose: shares a memory port between instruction fetch (A) and load/store
//          (B). Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> ACK.
// Ports:   Clk, Reset                 - clock, synchronous active-high reset
//          ReqA/AddrA/WDataA/WeA      - requester A (held until AckA)
//          ReqB/AddrB/WDataB/WeB      - requester B (held until AckB)
//          MemAddr/MemWData           - steered address / write data
//          MemEn/MemWe                - access / write strobes
//          MemRData                   - memory read data, valid on last ACCESS cycle
//          RData                      - captured read data, valid with Ack
//          AckA/AckB                  - one-cycle completion pulses
//          Sel                        - grant/steering select, 1=A, 0=B
//          Busy                       - high in ACCESS and ACK
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ReqA,
    input  logic [WIDTH-1:0] AddrA,
    input  logic [WIDTH-1:0] WDataA,
    input  logic             WeA,
    input  logic             ReqB,
    input  logic [WIDTH-1:0] AddrB,
    input  logic [WIDTH-1:0] WDataB,
    input  logic             WeB,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] MemWData,
    output logic             MemEn,
    output logic             MemWe,
    input  logic [WIDTH-1:0] MemRData,
    output logic [WIDTH-1:0] RData,
    output logic             AckA,
    output logic             AckB,
    output logic             Sel,
    output logic             Busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant_valid;
    logic             grant_id;

    rr_grant_picker u_picker (
        .req_a       (ReqA),
        .req_b       (ReqB),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            Sel        <= GRANT_B;
            last_grant <= GRANT_B;
            cnt        <= '0;
            RData      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        Sel   <= grant_id;
                        cnt   <= '0;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        // Memory presents read data on the final access cycle.
                        RData <= MemRData;
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // Round-robin history advances only on a completed access.
                    last_grant <= Sel;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mux2 #(.W(WIDTH)) u_addr_mux (
        .sel  (Sel),
        .in_a (AddrA),
        .in_b (AddrB),
        .out  (MemAddr)
    );

    mux2 #(.W(WIDTH)) u_wdata_mux (
        .sel  (Sel),
        .in_a (WDataA),
        .in_b (WDataB),
        .out  (MemWData)
    );

    assign MemEn = (state == ST_ACCESS);
    assign MemWe = MemEn & (Sel ? WeA : WeB);
    assign AckA  = (state == ST_ACK) &  Sel;
    assign AckB  = (state == ST_ACK) & ~Sel;
    assign Busy  = (state == ST_ACCESS) | (state == ST_ACK);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqA, WeA, ReqB, WeB;
    logic [31:0] AddrA, WDataA, AddrB, WDataB, MemRData;
    logic [31:0] MemAddr, MemWData, RData;
    logic        MemEn, MemWe, AckA, AckB, Sel, Busy;

    logic        ReqA1, WeA1, ReqB1, WeB1;
    logic [31:0] AddrA1, WDataA1, AddrB1, WDataB1, MemRData1;
    logic [31:0] MemAddr1, MemWData1, RData1;
    logic        MemEn1, MemWe1, AckA1, AckB1, Sel1, Busy1;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.WIDTH(32), .MEM_LAT(2)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .ReqA(ReqA), .AddrA(AddrA), .WDataA(WDataA), .WeA(WeA),
        .ReqB(ReqB), .AddrB(AddrB), .WDataB(WDataB), .WeB(WeB),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemEn(MemEn), .MemWe(MemWe),
        .MemRData(MemRData), .RData(RData), .AckA(AckA), .AckB(AckB),
        .Sel(Sel), .Busy(Busy)
    );

    mem_port_arbiter #(.WIDTH(32), .MEM_LAT(1)) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .ReqA(ReqA1), .AddrA(AddrA1), .WDataA(WDataA1), .WeA(WeA1),
        .ReqB(ReqB1), .AddrB(AddrB1), .WDataB(WDataB1), .WeB(WeB1),
        .MemAddr(MemAddr1), .MemWData(MemWData1), .MemEn(MemEn1), .MemWe(MemWe1),
        .MemRData(MemRData1), .RData(RData1), .AckA(AckA1), .AckB(AckB1),
        .Sel(Sel1), .Busy(Busy1)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        ReqA = 0; WeA = 0; AddrA = '0; WDataA = '0;
        ReqB = 0; WeB = 0; AddrB = '0; WDataB = '0;
        MemRData = '0;
        ReqA1 = 0; WeA1 = 0; AddrA1 = '0; WDataA1 = '0;
        ReqB1 = 0; WeB1 = 0; AddrB1 = '0; WDataB1 = '0;
        MemRData1 = '0;
        step();
        step();
        Reset = 1'b0;
        total++; if (Sel !== 1'b0) begin bad++; $display("FAIL reset_sel got=%0b exp=0", Sel); end
        total++; if (MemEn !== 1'b0) begin bad++; $display("FAIL reset_memen got=%0b exp=0", MemEn); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
        total++; if ({AckA, AckB} !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", {AckA, AckB}); end
        total++; if (RData !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", RData); end
        total++; if (MemWe !== 1'b0) begin bad++; $display("FAIL reset_memwe got=%0b exp=0", MemWe); end
    endtask

    task automatic test_single_read();
        ReqA = 1'b1; AddrA = 32'h40; MemRData = 32'hDEADBEEF;
        step();
        total++; if (MemEn !== 1'b1) begin bad++; $display("FAIL rd_memen_c1 got=%0b exp=1", MemEn); end
        total++; if (Sel !== 1'b1) begin bad++; $display("FAIL rd_sel got=%0b exp=1", Sel); end
        total++; if (MemAddr !== 32'h40) begin bad++; $display("FAIL rd_addr got=%h exp=40", MemAddr); end
        total++; if (AckA !== 1'b0) begin bad++; $display("FAIL rd_early_ack got=%0b exp=0", AckA); end
        step();
        total++; if (MemEn !== 1'b1) begin bad++; $display("FAIL rd_memen_c2 got=%0b exp=1", MemEn); end
        step();
        total++; if (MemEn !== 1'b0) begin bad++; $display("FAIL rd_memen_ack got=%0b exp=0", MemEn); end
        total++; if (AckA !== 1'b1) begin bad++; $display("FAIL rd_acka got=%0b exp=1", AckA); end
        total++; if (AckB !== 1'b0) begin bad++; $display("FAIL rd_ackb got=%0b exp=0", AckB); end
        total++; if (RData !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", RData); end
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rd_busy_ack got=%0b exp=1", Busy); end
        ReqA = 1'b0;
        step();
        total++; if (AckA !== 1'b0) begin bad++; $display("FAIL rd_ack_pulse got=%0b exp=0", AckA); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL rd_idle_busy got=%0b exp=0", Busy); end
        total++; if (Sel !== 1'b1) begin bad++; $display("FAIL rd_sel_hold got=%0b exp=1", Sel); end
        MemRData = 32'h0BADF00D;
        step();
        total++; if (RData !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata_hold got=%h exp=deadbeef", RData); end
    endtask

    task automatic test_alternate();
        logic exp_a;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        ReqA = 1'b1; AddrA = 32'h10;
        ReqB = 1'b1; AddrB = 32'h20;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            step();
            total++; if (Sel !== exp_a) begin bad++; $display("FAIL alt_sel[%0d] got=%0b exp=%0b", i, Sel, exp_a); end
            total++; if (MemAddr !== (exp_a ? 32'h10 : 32'h20)) begin bad++; $display("FAIL alt_addr[%0d] got=%h", i, MemAddr); end
            step();
            step();
            total++; if (AckA !== exp_a || AckB !== !exp_a) begin bad++; $display("FAIL alt_ack[%0d] got=%b exp=%b", i, {AckA, AckB}, {exp_a, !exp_a}); end
            step();
            total++; if ({AckA, AckB, MemEn} !== 3'b000) begin bad++; $display("FAIL alt_idle[%0d] got=%b exp=000", i, {AckA, AckB, MemEn}); end
        end
        ReqA = 1'b0; ReqB = 1'b0;
    endtask

    task automatic test_write_b();
        ReqB = 1'b1; WeB = 1'b1; AddrB = 32'h100; WDataB = 32'h12345678;
        WeA = 1'b0; WDataA = 32'hAAAAAAAA;
        total++; if (MemWe !== 1'b0) begin bad++; $display("FAIL wr_we_idle got=%0b exp=0", MemWe); end
        step();
        total++; if (MemWe !== 1'b1) begin bad++; $display("FAIL wr_we_c1 got=%0b exp=1", MemWe); end
        total++; if (MemWData !== 32'h12345678) begin bad++; $display("FAIL wr_wdata got=%h exp=12345678", MemWData); end
        total++; if (MemAddr !== 32'h100) begin bad++; $display("FAIL wr_addr got=%h exp=100", MemAddr); end
        total++; if (Sel !== 1'b0) begin bad++; $display("FAIL wr_sel got=%0b exp=0", Sel); end
        step();
        total++; if (MemWe !== 1'b1) begin bad++; $display("FAIL wr_we_c2 got=%0b exp=1", MemWe); end
        step();
        total++; if (MemWe !== 1'b0) begin bad++; $display("FAIL wr_we_ack got=%0b exp=0", MemWe); end
        total++; if ({AckA, AckB} !== 2'b01) begin bad++; $display("FAIL wr_ack got=%b exp=01", {AckA, AckB}); end
        ReqB = 1'b0; WeB = 1'b0;
        step();
        total++; if ({AckB, MemWe} !== 2'b00) begin bad++; $display("FAIL wr_after got=%b exp=00", {AckB, MemWe}); end
    endtask

    task automatic test_reset_mid_access();
        ReqA = 1'b1; AddrA = 32'h80; MemRData = 32'hCAFEF00D;
        step();
        total++; if (Sel !== 1'b1) begin bad++; $display("FAIL rm_sel got=%0b exp=1", Sel); end
        step();
        total++; if (MemEn !== 1'b1) begin bad++; $display("FAIL rm_memen_c2 got=%0b exp=1", MemEn); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        total++; if (MemEn !== 1'b0) begin bad++; $display("FAIL rm_memen got=%0b exp=0", MemEn); end
        total++; if ({AckA, AckB} !== 2'b00) begin bad++; $display("FAIL rm_ack got=%b exp=00", {AckA, AckB}); end
        total++; if (Sel !== 1'b0) begin bad++; $display("FAIL rm_sel_rst got=%0b exp=0", Sel); end
        total++; if (RData !== 32'h0) begin bad++; $display("FAIL rm_rdata got=%h exp=0", RData); end
        ReqA = 1'b1; ReqB = 1'b1;
        step();
        total++; if (Sel !== 1'b1) begin bad++; $display("FAIL rm_tie_a got=%0b exp=1", Sel); end
        step();
        step();
        total++; if (AckA !== 1'b1) begin bad++; $display("FAIL rm_acka got=%0b exp=1", AckA); end
        ReqA = 1'b0; ReqB = 1'b0;
        step();
    endtask

    task automatic test_drop_mid_access();
        ReqA = 1'b1; AddrA = 32'h44; MemRData = 32'h55AA55AA;
        step();
        ReqA = 1'b0;
        step();
        total++; if (MemEn !== 1'b1) begin bad++; $display("FAIL drop_memen got=%0b exp=1", MemEn); end
        step();
        total++; if (AckA !== 1'b1) begin bad++; $display("FAIL drop_acka got=%0b exp=1", AckA); end
        total++; if (RData !== 32'h55AA55AA) begin bad++; $display("FAIL drop_rdata got=%h exp=55aa55aa", RData); end
        step();
        total++; if ({Busy, MemEn, AckA} !== 3'b000) begin bad++; $display("FAIL drop_idle got=%b exp=000", {Busy, MemEn, AckA}); end
        step();
        total++; if (MemEn !== 1'b0) begin bad++; $display("FAIL drop_stay_idle got=%0b exp=0", MemEn); end
    endtask

    task automatic test_mem_lat1();
        ReqA1 = 1'b1; AddrA1 = 32'h300; MemRData1 = 32'h13579BDF;
        step();
        total++; if (MemEn1 !== 1'b1) begin bad++; $display("FAIL l1_memen got=%0b exp=1", MemEn1); end
        total++; if (MemAddr1 !== 32'h300) begin bad++; $display("FAIL l1_addr got=%h exp=300", MemAddr1); end
        step();
        total++; if (MemEn1 !== 1'b0) begin bad++; $display("FAIL l1_memen_off got=%0b exp=0", MemEn1); end
        total++; if (AckA1 !== 1'b1) begin bad++; $display("FAIL l1_acka got=%0b exp=1", AckA1); end
        total++; if (RData1 !== 32'h13579BDF) begin bad++; $display("FAIL l1_rdata got=%h exp=13579bdf", RData1); end
        ReqA1 = 1'b0;
        step();
        total++; if ({AckA1, Busy1} !== 2'b00) begin bad++; $display("FAIL l1_idle got=%b exp=00", {AckA1, Busy1}); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_write_b();
        test_reset_mid_access();
        test_drop_mid_access();
        test_mem_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester round-robin arbiter sharing one 32-bit memory port between instruction-fetch (A) and load/store (B) in the processor. Sequences each access through a fixed-latency memory, captures read data and returns a one-cycle acknowledge to the winner. Drives the select of the address and write-data steering muxes (Sel=1 selects A, Sel=0 selects B).

Parameters:
WIDTH, 32, data/address width
MEM_LAT, 2, memory access latency in cycles (legal 1..15)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
ReqA  in  1  request from A; held until AckA
AddrA  in  WIDTH  A address
WDataA  in  WIDTH  A write data
WeA  in  1  A write enable
ReqB  in  1  request from B; held until AckB
AddrB  in  WIDTH  B address
WDataB  in  WIDTH  B write data
WeB  in  1  B write enable
MemAddr  out  WIDTH  steered address
MemWData  out  WIDTH  steered write data
MemEn  out  1  memory access strobe
MemWe  out  1  memory write strobe
MemRData  in  WIDTH  memory read data, valid on last ACCESS cycle
RData  out  WIDTH  registered read data, valid with Ack
AckA  out  1  one-cycle completion pulse to A
AckB  out  1  one-cycle completion pulse to B
Sel  out  1  grant/steering select, 1=A, 0=B
Busy  out  1  high in ACCESS and ACK

Behaviour:
- Reset (sync, active-high) -> state IDLE, Sel=0, LastGrant=B, counter=0, AckA=AckB=0, RData=0, MemEn=0, Busy=0. Reset wins over every other event.
- States: IDLE, ACCESS, ACK.
- IDLE: no req -> stay. Only one req -> grant it. Both -> grant the one not equal to LastGrant (first tie after reset goes to A). Grant registers Sel, clears counter, next=ACCESS.
- ACCESS: MemEn=1 for exactly MEM_LAT cycles; counter increments each cycle; on cycle counter==MEM_LAT-1 register MemRData into RData, next=ACK.
- ACK: AckA (Sel=1) or AckB (Sel=0) high for one cycle; LastGrant<=Sel; next=IDLE. Requests in ACK are ignored.
- Latency: Req sampled in IDLE at cycle t -> MemEn cycles t+1..t+MEM_LAT -> Ack at t+MEM_LAT+1. Next grant at earliest t+MEM_LAT+2.
- Steering is combinational from Sel: MemAddr = Sel?AddrA:AddrB, MemWData = Sel?WDataA:WDataB. MemWe = MemEn & (Sel?WeA:WeB). MemWe=0 outside ACCESS.
- Sel holds its value in IDLE; it changes only on a grant.
- RData holds until the next completed access. For writes RData captures MemRData anyway, and requesters ignore it.
- Requester contract: Req, address, data and We are stable from assertion through Ack. Req is low in the cycle after Ack unless a new request is issued. A back-to-back Req is legal and is arbitrated as new.
- Req dropped mid-ACCESS: the access still completes and Ack still pulses. No abort.
- Reset mid-ACCESS/ACK: MemEn and Ack drop in the next cycle, no Ack is issued, RData=0.
- Counter width is 4 bits. MEM_LAT=1 gives a single ACCESS cycle.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/ACK), GRANT_A=1/GRANT_B=0 constants, MEM_LAT width constant.
- Sub-module rr_grant_picker (combinational: ReqA, ReqB, LastGrant -> grant valid, grant id).
- Steering uses the team's standard 32-bit 2:1 mux (sel=1 selects first input), instantiated twice.

Test Plan:
- Reset, then ReqA only, AddrA=0x40, MEM_LAT=2, MemRData=0xDEADBEEF -> MemEn high 2 cycles, MemAddr=0x40, Sel=1, AckA pulses at cycle 3 with RData=0xDEADBEEF, AckB=0.
- ReqA and ReqB asserted together, held after each Ack -> grants alternate A,B,A,B; Acks are 4 cycles apart (MEM_LAT=2); neither requester is starved.
- ReqB write: WeB=1, AddrB=0x100, WDataB=0x12345678 -> MemWe=1 for exactly 2 cycles, MemWData=0x12345678, AckB one cycle, MemWe=0 elsewhere.
- Reset asserted in 2nd ACCESS cycle -> next cycle MemEn=0, no Ack, Sel=0, RData=0; following ReqB+ReqA tie grants A.
- MEM_LAT=1 build, ReqA -> MemEn one cycle, AckA two cycles after request sampled.
- ReqA dropped during ACCESS -> access completes, AckA still pulses, then returns to IDLE.
